ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
- REQ-001: Parameter CTRL_W, default 5, width of one control word (reg_wr, wr_en, rd_en, wb_sel[1:0]).
- REQ-002: Parameter DEPTH, default 2, number of register stages; legal range 1..8.
- REQ-003: Parameter NOP_VALUE, default all-zero CTRL_W, control word held by any invalid stage.
- REQ-004: clk  input  1  sole clock; all state updates on rising edge.
- REQ-005: rst  input  1  asynchronous, active-low reset.
- REQ-006: ctrl_in  input  CTRL_W  control word entering stage 0.
- REQ-007: valid_in  input  1  ctrl_in carries a real instruction.
- REQ-008: stall  input  DEPTH  per-stage stall request; bit k freezes stages 0..k.
- REQ-009: flush  input  DEPTH  per-stage flush request; bit k kills stage k.
- REQ-010: ctrl_out  output  DEPTH*CTRL_W  all stage registers; stage k at bits [k*CTRL_W +: CTRL_W].
- REQ-011: valid_out  output  DEPTH  valid bit of every stage.
- REQ-012: ctrl_last / valid_last  output  CTRL_W / 1  copies of stage DEPTH-1.
- REQ-013: occupancy  output  clog2(DEPTH+1)  count of set valid_out bits.
- REQ-014: flush_cnt  output  16  saturating count of cycles with any flush bit set.

Function
- REQ-015: Define hold[k] = OR of stall[j] for j >= k; all decisions sampled at the rising edge.
- REQ-016: Invariant: a stage whose valid bit is 0 holds NOP_VALUE in its ctrl register.
- REQ-017: Priority per stage k, highest first: flush[k] -> bubble; hold[k] -> keep contents; k>0 and hold[k-1] -> bubble; else advance.
- REQ-018: Bubble: valid 0, ctrl NOP_VALUE.
- REQ-019: Advance, stage 0: valid <= valid_in; ctrl <= ctrl_in if valid_in else NOP_VALUE.
- REQ-020: Advance, stage k>0: valid and ctrl <= previous-cycle values of stage k-1.
- REQ-021: Latency: an unstalled, unflushed word at ctrl_in appears at stage k k+1 cycles later (ctrl_last after DEPTH cycles).
- REQ-022: Flush of stage k does not affect stage k+1 in the same cycle; stage k+1 still captures stage k's old contents unless itself flushed or held.
- REQ-023: Simultaneous stall[k] and flush[k]: stage k becomes a bubble; stages 0..k-1 stay frozen.
- REQ-024: Word leaving stage DEPTH-1 is discarded, regardless of stall.
- REQ-025: occupancy and ctrl_last/valid_last are combinational from stage registers; no added latency.
- REQ-026: flush_cnt increments by 1 each cycle |flush is 1; holds at 16'hFFFF, never wraps.
- REQ-027: DEPTH=1: hold[0]=stall[0]; only stage-0 rules apply.

Reset
- REQ-028: rst low asynchronously forces every valid bit to 0, every ctrl stage to NOP_VALUE, flush_cnt to 0, independent of clk.
- REQ-029: While rst is low, outputs stay at reset values; stall, flush, valid_in ignored.
- REQ-030: First rising edge with rst high performs a normal update per REQ-017.
- REQ-031: Reset asserted mid-stall or mid-flush discards all in-flight words; none reappear after release.

Verification (DEPTH=2, CTRL_W=5, NOP_VALUE=0)
- REQ-032: Stream valid_in=1, ctrl_in 5'h11, 5'h0A, 5'h1F on consecutive edges, no stall/flush -> ctrl_last 5'h11, 5'h0A, 5'h1F on edges 2, 3, 4; occupancy reaches 2.
- REQ-033: Pipe holds {s0=5'h0A, s1=5'h11}; stall=2'b01 one cycle -> s0 stays 5'h0A, s1 becomes bubble (valid 0, ctrl 0), occupancy 1.
- REQ-034: Same state, stall=2'b10 -> both stages hold, ctrl_in ignored, occupancy 2.
- REQ-035: Pipe full; flush=2'b01 with valid_in=1, ctrl_in=5'h03 -> s0 bubble, s1 takes old s0; next edge ctrl_last=0, valid_last=0.
- REQ-036: Pipe full, stall=2'b01 and flush=2'b01 together -> s0 bubble, s1 bubble, flush_cnt +1.
- REQ-037: Hold flush nonzero 65540 cycles -> flush_cnt 16'hFFFF, no wrap; drop rst mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Parameterised pipeline of control-word registers with per-stage
//            stall and flush. A stall at stage k freezes stages 0..k and puts
//            a bubble into stage k+1. A flush at stage k turns stage k into a
//            bubble. An invalid stage always holds NOP_VALUE.
// Ports    : clk        - sole clock, rising edge
//            rst        - asynchronous, active-low reset
//            ctrl_in    - control word entering stage 0
//            valid_in   - ctrl_in carries a real instruction
//            stall      - per-stage stall request (bit k freezes 0..k)
//            flush      - per-stage flush request (bit k kills stage k)
//            ctrl_out   - all stage registers, stage k at [k*CTRL_W +: CTRL_W]
//            valid_out  - valid bit of every stage
//            ctrl_last  - control word of the last stage
//            valid_last - valid bit of the last stage
//            occupancy  - number of valid stages
//            flush_cnt  - saturating count of cycles with any flush bit set
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int unsigned       CTRL_W    = 5,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [CTRL_W-1:0] NOP_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CTRL_W-1:0]          ctrl_in,
    input  logic                       valid_in,
    input  logic [DEPTH-1:0]           stall,
    input  logic [DEPTH-1:0]           flush,
    output logic [DEPTH*CTRL_W-1:0]    ctrl_out,
    output logic [DEPTH-1:0]           valid_out,
    output logic [CTRL_W-1:0]          ctrl_last,
    output logic                       valid_last,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                flush_cnt
);

    localparam int unsigned OCC_W     = $clog2(DEPTH + 1);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [DEPTH-1:0]  w_hold;
    logic [CTRL_W-1:0] r_ctrl  [DEPTH];
    logic              r_valid [DEPTH];
    logic [15:0]       r_flush_cnt;

    // w_hold[k] is set when any stall at or downstream of stage k is raised,
    // because a downstream freeze must back-pressure every stage behind it.
    always_comb begin
        w_hold            = '0;
        w_hold[DEPTH-1]   = stall[DEPTH-1];
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            w_hold[k] = stall[k] | w_hold[k+1];
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_valid[0] <= 1'b0;
                        r_ctrl[0]  <= NOP_VALUE;
                    end else if (flush[0]) begin
                        r_valid[0] <= 1'b0;
                        r_ctrl[0]  <= NOP_VALUE;
                    end else if (!w_hold[0]) begin
                        r_valid[0] <= valid_in;
                        r_ctrl[0]  <= valid_in ? ctrl_in : NOP_VALUE;
                    end
                end
            end else begin : g_body
                // Flush beats hold; a held stage keeps its word; if only the
                // upstream stage is held this stage drains into a bubble.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        r_valid[k] <= 1'b0;
                        r_ctrl[k]  <= NOP_VALUE;
                    end else if (flush[k]) begin
                        r_valid[k] <= 1'b0;
                        r_ctrl[k]  <= NOP_VALUE;
                    end else if (!w_hold[k]) begin
                        if (w_hold[k-1]) begin
                            r_valid[k] <= 1'b0;
                            r_ctrl[k]  <= NOP_VALUE;
                        end else begin
                            r_valid[k] <= r_valid[k-1];
                            r_ctrl[k]  <= r_ctrl[k-1];
                        end
                    end
                end
            end

            assign ctrl_out[k*CTRL_W +: CTRL_W] = r_ctrl[k];
            assign valid_out[k]                 = r_valid[k];
        end
    endgenerate

    assign ctrl_last  = r_ctrl[DEPTH-1];
    assign valid_last = r_valid[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occupancy = occupancy + OCC_W'(valid_out[k]);
        end
    end

    // Saturates rather than wraps so a long flush storm stays visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_cnt <= '0;
        end else if ((|flush) && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Self-checking bench for ctrl_pipe (DEPTH=2, CTRL_W=5, NOP=0).
//            The driver updates a stage-array reference model and queues the
//            expected post-edge state; a monitor pops and compares after each
//            rising edge. Directed checks cover the reset, stall, flush and
//            saturation corner cases.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam int          DEPTH  = 2;
    localparam int          CTRL_W = 5;
    localparam logic [4:0]  NOP    = 5'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ctrl_in;
    logic        valid_in;
    logic [1:0]  stall;
    logic [1:0]  flush;
    logic [9:0]  ctrl_out;
    logic [1:0]  valid_out;
    logic [4:0]  ctrl_last;
    logic        valid_last;
    logic [1:0]  occupancy;
    logic [15:0] flush_cnt;

    ctrl_pipe #(
        .CTRL_W    (CTRL_W),
        .DEPTH     (DEPTH),
        .NOP_VALUE (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .stall      (stall),
        .flush      (flush),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .ctrl_last  (ctrl_last),
        .valid_last (valid_last),
        .occupancy  (occupancy),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [9:0]  c;
        logic [15:0] fc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;

    bit         mv[2];
    logic [4:0] mc[2];
    int         mfc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0;
            mc[k] = NOP;
        end
        mfc = 0;
    endfunction

    // Next pipeline state straight from the stage rules: flush, then hold
    // (any stall at or after k), then bubble behind a held upstream stage,
    // else advance.
    function automatic void model_step(input logic [4:0] ci, input logic vi,
                                       input logic [1:0] st, input logic [1:0] fl);
        bit         nv[2];
        logic [4:0] nc[2];
        for (int k = 0; k < 2; k++) begin
            bit held    = (st >> k) != 0;
            bit up_held = (k > 0) ? ((st >> (k - 1)) != 0) : 1'b0;
            if (fl[k]) begin
                nv[k] = 1'b0; nc[k] = NOP;
            end else if (held) begin
                nv[k] = mv[k]; nc[k] = mc[k];
            end else if (up_held) begin
                nv[k] = 1'b0; nc[k] = NOP;
            end else if (k == 0) begin
                nv[0] = vi; nc[0] = vi ? ci : NOP;
            end else begin
                nv[k] = mv[(k == 0) ? 0 : k - 1];
                nc[k] = mc[(k == 0) ? 0 : k - 1];
            end
        end
        for (int k = 0; k < 2; k++) begin
            mv[k] = nv[k];
            mc[k] = nc[k];
        end
        if (fl != 2'b00 && mfc < 65535) mfc++;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.v  = {mv[1], mv[0]};
        e.c  = {mc[1], mc[0]};
        e.fc = mfc[15:0];
        return e;
    endfunction

    task automatic drive(input logic [4:0] ci, input logic vi,
                         input logic [1:0] st, input logic [1:0] fl);
        ctrl_in  = ci;
        valid_in = vi;
        stall    = st;
        flush    = fl;
        model_step(ci, vi, st, fl);
        sb.push_back(snap());
    endtask

    task automatic cycle(input logic [4:0] ci, input logic vi,
                         input logic [1:0] st, input logic [1:0] fl);
        @(negedge clk);
        drive(ci, vi, st, fl);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_cycle(input bit force_flush);
        logic [1:0] st;
        logic [1:0] fl;
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        fl = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
        if (force_flush) fl = fl | 2'b01;
        cycle(5'($urandom), 1'($urandom), st, fl);
    endtask

    // Monitor: one queued expectation per driven edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ctrl_out",   32'(ctrl_out),   32'(e.c));
                check("valid_out",  32'(valid_out),  32'(e.v));
                check("ctrl_last",  32'(ctrl_last),  32'(e.c[9:5]));
                check("valid_last", 32'(valid_last), 32'(e.v[1]));
                check("occupancy",  32'(occupancy),  32'(e.v[0]) + 32'(e.v[1]));
                check("flush_cnt",  32'(flush_cnt),  32'(e.fc));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        ctrl_in  = '0;
        valid_in = 1'b0;
        stall    = '0;
        flush    = '0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_ctrl_out",  32'(ctrl_out),  32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        rst = 1'b1;

        // Streaming latency
        cycle(5'h11, 1'b1, 2'b00, 2'b00);
        cycle(5'h0A, 1'b1, 2'b00, 2'b00);
        after_edge();
        check("stream_last_e2", 32'(ctrl_last), 32'h11);
        check("stream_occ",     32'(occupancy), 32'd2);
        cycle(5'h1F, 1'b1, 2'b00, 2'b00);
        after_edge();
        check("stream_last_e3", 32'(ctrl_last), 32'h0A);
        cycle(5'h00, 1'b0, 2'b00, 2'b00);
        after_edge();
        check("stream_last_e4", 32'(ctrl_last), 32'h1F);

        // Stall stage 0 only: s0 keeps, s1 becomes a bubble
        cycle(5'h11, 1'b1, 2'b00, 2'b00);
        cycle(5'h0A, 1'b1, 2'b00, 2'b00);
        cycle(5'h05, 1'b1, 2'b01, 2'b00);
        after_edge();
        check("stall01_valid", 32'(valid_out), 32'b01);
        check("stall01_ctrl",  32'(ctrl_out),  32'h00A);
        check("stall01_occ",   32'(occupancy), 32'd1);

        // Stall stage 1: both hold, ctrl_in ignored
        cycle(5'h11, 1'b1, 2'b00, 2'b00);
        cycle(5'h0A, 1'b1, 2'b00, 2'b00);
        cycle(5'h1F, 1'b1, 2'b10, 2'b00);
        after_edge();
        check("stall10_ctrl", 32'(ctrl_out),  {22'h0, 5'h11, 5'h0A});
        check("stall10_occ",  32'(occupancy), 32'd2);

        // Flush stage 0 while full: s1 still takes old s0
        cycle(5'h03, 1'b1, 2'b00, 2'b01);
        after_edge();
        check("flush01_valid", 32'(valid_out), 32'b10);
        check("flush01_ctrl",  32'(ctrl_out),  {22'h0, 5'h0A, 5'h00});
        cycle(5'h00, 1'b0, 2'b00, 2'b00);
        after_edge();
        check("flush01_last",  32'(ctrl_last),  32'h0);
        check("flush01_vlast", 32'(valid_last), 32'h0);

        // Stall and flush stage 0 together while full
        cycle(5'h11, 1'b1, 2'b00, 2'b00);
        cycle(5'h0A, 1'b1, 2'b00, 2'b00);
        cycle(5'h15, 1'b1, 2'b01, 2'b01);
        after_edge();
        check("sf_valid", 32'(valid_out), 32'b00);
        check("sf_ctrl",  32'(ctrl_out),  32'h0);
        check("sf_fcnt",  32'(flush_cnt), 32'd2);

        // Randomised traffic
        repeat (400) rand_cycle(1'b0);

        // Saturation of the flush counter
        repeat (65540) rand_cycle(1'b1);
        after_edge();
        check("fcnt_sat", 32'(flush_cnt), 32'hFFFF);
        repeat (4) rand_cycle(1'b1);
        after_edge();
        check("fcnt_nowrap", 32'(flush_cnt), 32'hFFFF);

        // Fill, then asynchronous reset in the middle of a cycle
        cycle(5'h1C, 1'b1, 2'b00, 2'b00);
        cycle(5'h0E, 1'b1, 2'b01, 2'b00);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(valid_out), 32'h0);
        check("arst_ctrl",  32'(ctrl_out),  32'h0);
        check("arst_last",  32'(ctrl_last), 32'h0);
        check("arst_occ",   32'(occupancy), 32'h0);
        check("arst_fcnt",  32'(flush_cnt), 32'h0);
        repeat (3) begin
            @(negedge clk);
            ctrl_in  = 5'($urandom);
            valid_in = 1'b1;
            stall    = 2'($urandom);
            flush    = 2'($urandom);
            after_edge();
            check("inrst_valid", 32'(valid_out), 32'h0);
            check("inrst_fcnt",  32'(flush_cnt), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(5'h07, 1'b1, 2'b00, 2'b00);
        after_edge();
        check("rel_valid", 32'(valid_out), 32'b01);
        check("rel_ctrl",  32'(ctrl_out),  32'h007);
        repeat (3) cycle(5'h00, 1'b0, 2'b00, 2'b00);
        after_edge();
        check("rel_drained", 32'(valid_out), 32'h0);

        repeat (50) rand_cycle(1'b0);
        repeat (2) after_edge();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
